// File: rtl/t03_imm_gen_pipe.sv
// Pipelined RV immediate generator: combinational decode feeding a 2-entry
// skid buffer (main entry drives outputs, skid entry absorbs one overflow).
module t03_imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;
  localparam logic [2:0] FMT_SH   = 3'd7;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           m_q, m_d, s_q, s_d, dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, deliver;
  logic [2:0]       funct3;

  assign funct3 = in_instr[14:12];

  // Illegal encodings always carry fmt NONE and a zero immediate.
  always_comb begin
    dec     = '0;
    dec.tag = in_tag;
    case (in_instr[6:0])
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          if (XLEN == 32 && in_instr[25]) begin
            dec.ill = 1'b1;
          end else begin
            dec.fmt = FMT_SH;
            dec.imm = (XLEN == 32) ? XLEN'(in_instr[24:20]) : XLEN'(in_instr[25:20]);
          end
        end else begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(in_instr[31:20]));
        end
      end
      7'b0000011, 7'b1100111: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(in_instr[31:20]));
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      7'b1110011: begin
        if (in_instr[14]) begin
          dec.fmt = FMT_Z;
          dec.imm = XLEN'(in_instr[19:15]);
        end else begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(in_instr[31:20]));
        end
      end
      7'b0110011, 7'b0001111: begin
        dec.fmt = FMT_NONE;
      end
      default: begin
        dec.ill = 1'b1;
      end
    endcase
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  // The counter tracks deliveries independently of flush.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    if (deliver && m_q.ill && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            m_d     = dec;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && out_ready) begin
            m_d = dec;
          end else if (accept) begin
            s_d     = dec;
            state_d = FULL;
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            m_d     = s_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.ill;
  assign out_tag     = m_q.tag;
  assign illegal_cnt = cnt_q;

endmodule
